// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state encodings, opcodes and control-field codes
// Purpose: common definitions for the multicycle main controller, ALU decoder
//          and datapath. No ports.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_JAL     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// rtl/mc_ctrl_out_decode.sv - combinational state to control-word decode
// Purpose: Moore output decode for the multicycle controller.
// Ports:  i state (state_t), i mem_rdy (effective memory ready),
//         o pc_write, branch, pc_src[1:0], iord, mem_write, ir_write,
//           reg_dst[1:0], mem_to_reg[1:0], reg_write, alu_src_a,
//           alu_src_b[1:0], alu_op[1:0]
module mc_ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_rdy,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op
);

    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = PC_ALU;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        case (state)
            S_FETCH: begin
                // IR and PC only latch once the fetch data is actually back
                alu_src_b = SRCB_4;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
            end
            S_DECODE: begin
                // Speculative branch target: PC+4 + (SignImm<<2)
                alu_src_b = SRCB_IMM4;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = M2R_MEM;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = RD_RD;
                reg_write = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                branch    = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = RD_RA;
                mem_to_reg = M2R_PC;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_main_ctrl.sv
// rtl/multicycle_main_ctrl.sv - multicycle MIPS main control FSM
// Purpose: sequences FETCH/DECODE/execute/writeback for lw, sw, R-type,
//          addi, beq, j, jal with a memory-ready handshake.
// Ports:  i clk, rst_n (async active-low), op[5:0], mem_ready
//         o pc_write, branch, pc_src[1:0], iord, mem_write, ir_write,
//           reg_dst[1:0], mem_to_reg[1:0], reg_write, alu_src_a,
//           alu_src_b[1:0], alu_op[1:0], illegal_op (one-cycle pulse)
module multicycle_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit JAL_EN        = 1'b1,
    parameter int STATE_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op
);

    logic [STATE_W-1:0] r_state;
    logic               r_illegal;
    state_t             w_cur;
    state_t             w_next;
    logic               w_mem_rdy;
    logic               w_bad_op;

    assign w_cur     = state_t'(r_state[3:0]);
    assign w_mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        w_next   = S_IDLE;
        w_bad_op = 1'b0;
        case (w_cur)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = w_mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
                if (op == OP_JAL && JAL_EN) begin
                    w_next = S_JAL;
                end else if (w_next == S_FETCH) begin
                    w_bad_op = 1'b1;
                end
            end
            S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = w_mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_mem_rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL:
                       w_next = S_FETCH;
            default:   w_next = S_IDLE;
        endcase
    end

    // illegal_op is registered so it carries no combinational path from op;
    // it pulses in the cycle after the offending DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= STATE_W'(S_IDLE);
            r_illegal <= 1'b0;
        end else begin
            r_state   <= STATE_W'(w_next);
            r_illegal <= w_bad_op;
        end
    end

    assign illegal_op = r_illegal;

    mc_ctrl_out_decode u_decode (
        .state      (w_cur),
        .mem_rdy    (w_mem_rdy),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op)
    );

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// tb/tb_multicycle_main_ctrl.sv - directed self-checking bench for multicycle_main_ctrl
module tb_multicycle_main_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;

    logic       pc_write, branch, iord, mem_write, ir_write, reg_write, alu_src_a, illegal_op;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;

    logic       n_pc_write, n_branch, n_iord, n_mem_write, n_ir_write, n_reg_write, n_alu_src_a, n_illegal_op;
    logic [1:0] n_pc_src, n_reg_dst, n_mem_to_reg, n_alu_src_b, n_alu_op;

    int n_cmp = 0;
    int n_err = 0;

    // Word order: pw br pcs[2] iord mw irw rd[2] m2r[2] rw sa sb[2] aop[2] ill
    localparam logic [17:0] E_IDLE   = 18'b0;
    localparam logic [17:0] E_FETCH  = {1'b1,1'b0,2'b00,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,1'b0};
    localparam logic [17:0] E_FETCHW = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,1'b0};
    localparam logic [17:0] E_FETCHI = {1'b1,1'b0,2'b00,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,1'b0,2'b01,2'b00,1'b1};
    localparam logic [17:0] E_DECODE = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b11,2'b00,1'b0};
    localparam logic [17:0] E_MEMADR = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,1'b0};
    localparam logic [17:0] E_MEMRD  = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,1'b0};
    localparam logic [17:0] E_MEMWB  = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,2'b00,2'b00,1'b0};
    localparam logic [17:0] E_MEMWR  = {1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,1'b0};
    localparam logic [17:0] E_EXEC   = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b10,1'b0};
    localparam logic [17:0] E_ALUWB  = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,1'b0,2'b00,2'b00,1'b0};
    localparam logic [17:0] E_ADDIEX = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b10,2'b00,1'b0};
    localparam logic [17:0] E_ADDIWB = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,2'b00,2'b00,1'b0};
    localparam logic [17:0] E_BRANCH = {1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,2'b00,2'b01,1'b0};
    localparam logic [17:0] E_JUMP   = {1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,2'b00,2'b00,1'b0};
    localparam logic [17:0] E_JAL    = {1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,2'b10,2'b10,1'b1,1'b0,2'b00,2'b00,1'b0};

    logic [17:0] w_word, w_nword;
    assign w_word  = {pc_write, branch, pc_src, iord, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op};
    assign w_nword = {n_pc_write, n_branch, n_pc_src, n_iord, n_mem_write, n_ir_write, n_reg_dst,
                      n_mem_to_reg, n_reg_write, n_alu_src_a, n_alu_src_b, n_alu_op, n_illegal_op};

    multicycle_main_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .pc_src(pc_src), .iord(iord),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op)
    );

    multicycle_main_ctrl #(.JAL_EN(1'b0)) dut_nj (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .branch(n_branch), .pc_src(n_pc_src), .iord(n_iord),
        .mem_write(n_mem_write), .ir_write(n_ir_write), .reg_dst(n_reg_dst),
        .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .illegal_op(n_illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 6'b000000;
        mem_ready = 1'b1;
        step();
        step();
        chk("reset_idle", w_word, E_IDLE);
        chk("reset_idle_nj", w_nword, E_IDLE);

        rst_n = 1'b1;
        #1;
        chk("idle_after_release", w_word, E_IDLE);

        // lw, no waits
        step(); op = 6'b100011; #1;
        chk("lw_fetch", w_word, E_FETCH);
        step(); chk("lw_decode", w_word, E_DECODE);
        step(); chk("lw_memadr", w_word, E_MEMADR);
        step(); chk("lw_memrd", w_word, E_MEMRD);
        step(); chk("lw_memwb", w_word, E_MEMWB);

        // sw with three wait cycles in MEMWR
        step(); op = 6'b101011; #1;
        chk("sw_fetch", w_word, E_FETCH);
        step(); chk("sw_decode", w_word, E_DECODE);
        step(); chk("sw_memadr", w_word, E_MEMADR);
        mem_ready = 1'b0;
        step(); chk("sw_memwr_w1", w_word, E_MEMWR);
        step(); chk("sw_memwr_w2", w_word, E_MEMWR);
        step(); chk("sw_memwr_w3", w_word, E_MEMWR);
        step(); mem_ready = 1'b1; #1;
        chk("sw_memwr_done", w_word, E_MEMWR);

        // R-type with one fetch wait cycle
        step(); op = 6'b000000; mem_ready = 1'b0; #1;
        chk("r_fetch_wait", w_word, E_FETCHW);
        step(); chk("r_fetch_wait2", w_word, E_FETCHW);
        mem_ready = 1'b1; #1;
        chk("r_fetch_ready", w_word, E_FETCH);
        step(); chk("r_decode", w_word, E_DECODE);
        step(); chk("r_execute", w_word, E_EXEC);
        step(); chk("r_aluwb", w_word, E_ALUWB);

        // addi
        step(); op = 6'b001000; #1;
        chk("addi_fetch", w_word, E_FETCH);
        step(); chk("addi_decode", w_word, E_DECODE);
        step(); chk("addi_ex", w_word, E_ADDIEX);
        step(); chk("addi_wb", w_word, E_ADDIWB);

        // beq
        step(); op = 6'b000100; #1;
        chk("beq_fetch", w_word, E_FETCH);
        step(); chk("beq_decode", w_word, E_DECODE);
        step(); chk("beq_branch", w_word, E_BRANCH);

        // j
        step(); op = 6'b000010; #1;
        chk("j_fetch", w_word, E_FETCH);
        step(); chk("j_decode", w_word, E_DECODE);
        step(); chk("j_jump", w_word, E_JUMP);

        // jal: both instances have run in lockstep up to here
        step(); op = 6'b000011; #1;
        chk("jal_fetch", w_word, E_FETCH);
        chk("jal_fetch_nj", w_nword, E_FETCH);
        step(); chk("jal_decode", w_word, E_DECODE);
        step(); chk("jal_jal", w_word, E_JAL);
        chk("jal_nj_illegal", w_nword, E_FETCHI);
        step(); op = 6'b111111; #1;
        chk("jal_back_fetch", w_word, E_FETCH);
        chk("jal_nj_pulse_end", w_nword, E_DECODE);

        // unsupported opcode
        step(); chk("bad_decode", w_word, E_DECODE);
        step(); chk("bad_illegal_fetch", w_word, E_FETCHI);
        step(); op = 6'b000000; #1;
        chk("bad_pulse_end", w_word, E_DECODE);
        step(); chk("rst_exec", w_word, E_EXEC);

        // asynchronous reset mid-instruction
        rst_n = 1'b0; #1;
        chk("rst_async_idle", w_word, E_IDLE);
        chk("rst_async_idle_nj", w_nword, E_IDLE);
        step(); chk("rst_hold_idle", w_word, E_IDLE);
        rst_n = 1'b1;
        step(); chk("rst_release_fetch", w_word, E_FETCH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
